reimu_shot_pool: RTL



---
 rtl/reimu_shot_pool.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/reimu_shot_pool.sv
// Multi-slot player shot engine: rate-limited spawn, three-zone upward motion and,
// when REIMU_SHOT_HIT_EN is defined, collision against one target box with saturating HP.
module reimu_shot_pool #(
  parameter int SLOTS    = 4,
  parameter int W        = 10,
  parameter int COOLDOWN = 8,
  parameter int HALF_W   = 41,
  parameter int HALF_H   = 24,
  parameter int HP_W     = 10,
  parameter int HP_INIT  = 500,
  parameter int DMG      = 2
) (
  input  logic               clk_22,
  input  logic               rst,
  input  logic               step_en,
  input  logic               fire,
  input  logic [W-1:0]       reimux,
  input  logic [W-1:0]       reimuy,
  input  logic [W-1:0]       targetx,
  input  logic [W-1:0]       targety,
  output logic [SLOTS*W-1:0] bullet_x,
  output logic [SLOTS*W-1:0] bullet_y,
  output logic [SLOTS-1:0]   bullet_vld,
  output logic               fire_ack,
  output logic [SLOTS-1:0]   hit,
  output logic [HP_W-1:0]    target_hp
);

  localparam int CD_W = $clog2(COOLDOWN + 2);

  logic [W-1:0]      r_x [SLOTS];
  logic [W-1:0]      r_y [SLOTS];
  logic [SLOTS-1:0]  r_vld;
  logic [SLOTS-1:0]  r_hit;
  logic              r_fire_ack;
  logic [CD_W-1:0]   r_cd;
  logic [HP_W-1:0]   r_hp;

  logic [SLOTS-1:0]  w_sel;
  logic              w_found;
  logic              w_fire_ok;
  logic [SLOTS-1:0]  w_hit;
  logic [HP_W-1:0]   w_hp_nxt;
  logic [2:0]        w_step [SLOTS];

  // Free means invalid at the start of the cycle, so a slot retiring now is not reusable yet.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!r_vld[i] && !w_found) begin
        w_sel[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
    w_fire_ok = fire && (r_cd == '0) && w_found;
  end

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      if (r_y[i] <= W'(120))      w_step[i] = 3'd1;
      else if (r_y[i] <= W'(240)) w_step[i] = 3'd2;
      else                        w_step[i] = 3'd4;
    end
  end

`ifdef REIMU_SHOT_HIT_EN
  logic [3:0]      w_nhits;
  logic [HP_W+3:0] w_dmg;

  // Differences are taken one bit wider than the coordinates so targets near 0 stay signed-correct.
  always_comb begin : collide
    logic [W:0] w_dx, w_dy, w_ax, w_ay;
    w_hit   = '0;
    w_nhits = '0;
    for (int i = 0; i < SLOTS; i++) begin
      w_dx     = {1'b0, r_x[i]} - {1'b0, targetx};
      w_dy     = {1'b0, r_y[i]} - {1'b0, targety};
      w_ax     = w_dx[W] ? (~w_dx + 1'b1) : w_dx;
      w_ay     = w_dy[W] ? (~w_dy + 1'b1) : w_dy;
      w_hit[i] = step_en && r_vld[i] && (w_ax <= (W+1)'(HALF_W)) && (w_ay <= (W+1)'(HALF_H));
      w_nhits  = w_nhits + {3'b000, w_hit[i]};
    end
    w_dmg = (HP_W+4)'(DMG) * (HP_W+4)'(w_nhits);
    if ({4'b0000, r_hp} <= w_dmg) w_hp_nxt = '0;
    else                          w_hp_nxt = r_hp - w_dmg[HP_W-1:0];
  end
`else
  logic w_unused;
  assign w_unused = ^{targetx, targety, HALF_W[0], HALF_H[0], DMG[0]};
  assign w_hit    = '0;
  assign w_hp_nxt = HP_W'(HP_INIT);
`endif

  always_ff @(posedge clk_22) begin
    if (rst) begin
      r_vld      <= '0;
      r_hit      <= '0;
      r_fire_ack <= 1'b0;
      r_cd       <= '0;
      r_hp       <= HP_W'(HP_INIT);
      for (int i = 0; i < SLOTS; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      r_fire_ack <= w_fire_ok;
      r_hit      <= w_hit;
      r_hp       <= w_hp_nxt;
      if (w_fire_ok)                   r_cd <= CD_W'(COOLDOWN);
      else if (step_en && r_cd != '0)  r_cd <= r_cd - 1'b1;
      // A freshly loaded slot is not moved or collided in its load cycle.
      for (int i = 0; i < SLOTS; i++) begin
        if (w_fire_ok && w_sel[i]) begin
          r_x[i]   <= reimux;
          r_y[i]   <= reimuy;
          r_vld[i] <= 1'b1;
        end else if (step_en && r_vld[i]) begin
          if (w_hit[i] || (r_y[i] < W'(w_step[i]))) r_vld[i] <= 1'b0;
          else                                      r_y[i]   <= r_y[i] - W'(w_step[i]);
        end
      end
    end
  end

  always_comb begin
    bullet_x = '0;
    bullet_y = '0;
    for (int i = 0; i < SLOTS; i++) begin
      bullet_x[i*W +: W] = r_x[i];
      bullet_y[i*W +: W] = r_y[i];
    end
  end

  assign bullet_vld = r_vld;
  assign fire_ack   = r_fire_ack;
  assign hit        = r_hit;
  assign target_hp  = r_hp;

endmodule
